multi_control_hs: RTL and testbench
===================================

# multi_control_hs

Parametrised successor to the multi-cycle CPU control unit: a Moore FSM driving the multi-cycle datapath (PC, IR, MDR, A/B, ALUOut, muxes), extended with BNE, ADDI, ORI and JAL. It adds a memory-ready handshake with bounded wait states, so the datapath can use variable-latency memory. It sits between the instruction register opcode field and the datapath enables/mux selects in the CPU top.

## Interface
- TIMEOUT, 15: maximum consecutive not-ready cycles tolerated in any memory state before abort; legal range 1..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- OP  in  6  IR[31:26] opcode.
- mem_ready  in  1  memory has completed the current access this cycle.
- PCWrite, PCWriteCond, PCWriteCondN  out  1 each  unconditional PC write; write PC if Zero; write PC if !Zero.
- IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, ExtOp  out  1 each  datapath controls; ExtOp=1 selects sign extension, 0 selects zero extension.
- PCSource, ALUOp, ALUSrcB  out  2 each  ALUOp: 00 add, 01 sub, 10 funct, 11 or.
- RegDst  out  2  00 rt, 01 rd, 10 constant 31.
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC.
- LED  out  5  instruction class: [4] J/JAL, [3] BEQ/BNE, [2] LW, [1] SW, [0] R/ADDI/ORI.
- state  out  4  current state encoding, for debug display.
- err  out  1  sticky fault flag.

## Operation
- Opcodes:
  - R 000000, LW 100011, SW 101011
  - BEQ 000100, BNE 000101
  - ADDI 001000, ORI 001101
  - J 000010, JAL 000011
- States, with outputs; unlisted controls are 0:
  - 0 FETCH: MemRead, ALUSrcB=01. When mem_ready: IRWrite, PCWrite, PCSource=00, then go to DECODE.
  - 1 DECODE: ALUSrcB=11, ExtOp=1. Latch LED class. Dispatch: LW/SW→MEMADR, R→EXEC, BEQ/BNE→BRANCH, ADDI/ORI→IEXEC, J/JAL→JUMP, other→FETCH with err set.
  - 2 MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1. Go to MEMRD for LW, MEMWR for SW.
  - 3 MEMRD: MemRead, IorD. When mem_ready, go to MEMWB.
  - 4 MEMWB: RegWrite, MemtoReg=01, RegDst=00, then FETCH.
  - 5 MEMWR: IorD, MemWrite held asserted until mem_ready, then FETCH.
  - 6 EXEC: ALUSrcA=1, ALUOp=10, then RWB.
  - 7 RWB: RegWrite, RegDst=01, then FETCH.
  - 8 BRANCH: ALUSrcA=1, ALUOp=01, PCSource=01. PCWriteCond for BEQ, PCWriteCondN for BNE. Then FETCH.
  - 9 JUMP: PCWrite, PCSource=10. For JAL only, also RegWrite, RegDst=10, MemtoReg=10 (PC already holds PC+4). Then FETCH.
  - 10 IEXEC: ALUSrcA=1, ALUSrcB=10. ADDI: ALUOp=00, ExtOp=1. ORI: ALUOp=11, ExtOp=0. Then IWB.
  - 11 IWB: RegWrite, RegDst=00, MemtoReg=00, then FETCH.
- Wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR, and whenever mem_ready=1.
  - Increments on each cycle in which one of those states sees mem_ready=0.
  - Counter reaching TIMEOUT with mem_ready still 0 is a timeout: set err, go to FETCH, suppress IRWrite, PCWrite and all register writes that cycle.
- err is sticky until reset; the FSM continues running after err is set.
- mem_ready and timeout in the same cycle: mem_ready wins, normal transition.

## Timing
- All outputs are decoded combinationally from the registered state (and OP/mem_ready where noted). No output depends on Zero.
- Reset (rst low, asynchronous): state=FETCH, counter=0, err=0, LED=0. All write enables and MemRead are forced to 0 while rst is low.
- First FETCH outputs appear in the cycle after rst rises.
- Latency with zero wait, in cycles: R 4, LW 5, SW 4, BEQ/BNE 3, J/JAL 3, ADDI/ORI 4. Each not-ready cycle adds 1.
- rst asserted mid-instruction aborts immediately; no partial write completes after the reset edge.

## Configuration
- MULTI_CTRL_HS_EN defined: the handshake, wait counter and timeout operate as specified.
- MULTI_CTRL_HS_EN undefined:
  - mem_ready is ignored and treated as 1; the counter and timeout logic are not synthesised.
  - Each memory state lasts exactly one cycle, giving original fixed-latency behaviour.
  - err is set only by an illegal opcode.

## Test plan
- Reset, release, OP=000000, mem_ready=1: state sequence 0,1,6,7,0. RegWrite=1 and RegDst=01 only in state 7. LED=00001.
- LW with mem_ready low for 3 cycles in MEMRD: MEMRD is held 4 cycles with MemRead=IorD=1. MEMWB follows with MemtoReg=01. Total 8 cycles. err=0.
- BNE, then BEQ: PCWriteCondN=1, PCWriteCond=0 for BNE and the opposite for BEQ. Both use PCSource=01, ALUOp=01, LED=01000.
- JAL: JUMP asserts PCWrite, RegWrite, RegDst=10, MemtoReg=10, PCSource=10 in the same cycle. ORI: IEXEC has ALUOp=11, ExtOp=0.
- TIMEOUT=4, mem_ready held 0 in FETCH: after 4 wait cycles err=1 and the FSM re-enters FETCH. IRWrite and PCWrite are never asserted. Illegal OP=111111 also sets err.
- rst pulsed low during MEMWR: MemWrite drops asynchronously and state=0 on release. With the macro undefined, mem_ready=0 has no effect.

Source files
------------

// File: rtl/multi_control_hs_if.sv
// Control bundle between the multi-cycle control FSM (master) and the datapath (slave).
interface multi_control_hs_if;
  logic [5:0] OP;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       PCWriteCondN;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       ALUSrcA;
  logic       ExtOp;
  logic [1:0] PCSource;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcB;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic [4:0] LED;
  logic [3:0] state;
  logic       err;

  modport master (
    input  OP, mem_ready,
    output PCWrite, PCWriteCond, PCWriteCondN, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, ALUSrcA, ExtOp, PCSource, ALUOp, ALUSrcB, RegDst, MemtoReg,
           LED, state, err
  );

  modport slave (
    output OP, mem_ready,
    input  PCWrite, PCWriteCond, PCWriteCondN, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, ALUSrcA, ExtOp, PCSource, ALUOp, ALUSrcB, RegDst, MemtoReg,
           LED, state, err
  );
endinterface

// File: rtl/multi_control_hs.sv
// Moore control FSM for the multi-cycle CPU with optional memory-ready handshake.
// Define MULTI_CTRL_HS_EN to enable the mem_ready wait states, wait counter and timeout.
module multi_control_hs #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input logic                clk,
  input logic                rst,
  multi_control_hs_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB   = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  if (TIMEOUT < 1 || TIMEOUT > 255 || (1 << CNT_W) <= TIMEOUT) begin : g_bad_cfg
    $error("multi_control_hs: TIMEOUT must be 1..255 and fit in CNT_W bits");
  end

  state_t     cur_st, nxt_st;
  logic [4:0] led_q, led_d;
  logic       err_q, err_set;
  logic       rdy, tmo;

  logic       pc_write, pc_write_cond, pc_write_cond_n, ior_d, mem_read, mem_write;
  logic       ir_write, reg_write, alu_src_a, ext_op;
  logic [1:0] pc_source, alu_op, alu_src_b, reg_dst, mem_to_reg;

`ifdef MULTI_CTRL_HS_EN
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_st;

  assign rdy    = bus.mem_ready;
  assign mem_st = (cur_st == S_FETCH) || (cur_st == S_MEMRD) || (cur_st == S_MEMWR);
  // TIMEOUT not-ready cycles are tolerated; the next one aborts.
  assign tmo    = mem_st && !rdy && (wait_cnt == CNT_W'(TIMEOUT));

  // Any exit from a memory state is via ready or timeout, so entry always sees zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       wait_cnt <= '0;
    else if (rdy || tmo || !mem_st) wait_cnt <= '0;
    else                            wait_cnt <= wait_cnt + CNT_W'(1);
  end
`else
  assign rdy = 1'b1;
  assign tmo = 1'b0;
`endif

  always_comb begin
    nxt_st          = cur_st;
    err_set         = 1'b0;
    led_d           = led_q;
    pc_write        = 1'b0;
    pc_write_cond   = 1'b0;
    pc_write_cond_n = 1'b0;
    ior_d           = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    ir_write        = 1'b0;
    reg_write       = 1'b0;
    alu_src_a       = 1'b0;
    ext_op          = 1'b0;
    pc_source       = 2'b00;
    alu_op          = 2'b00;
    alu_src_b       = 2'b00;
    reg_dst         = 2'b00;
    mem_to_reg      = 2'b00;
    case (cur_st)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (rdy) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt_st   = S_DECODE;
        end else if (tmo) begin
          err_set = 1'b1;
          nxt_st  = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        ext_op    = 1'b1;
        case (bus.OP)
          OP_LW:           begin nxt_st = S_MEMADR; led_d = 5'b00100; end
          OP_SW:           begin nxt_st = S_MEMADR; led_d = 5'b00010; end
          OP_R:            begin nxt_st = S_EXEC;   led_d = 5'b00001; end
          OP_BEQ, OP_BNE:  begin nxt_st = S_BRANCH; led_d = 5'b01000; end
          OP_ADDI, OP_ORI: begin nxt_st = S_IEXEC;  led_d = 5'b00001; end
          OP_J, OP_JAL:    begin nxt_st = S_JUMP;   led_d = 5'b10000; end
          default:         begin nxt_st = S_FETCH;  led_d = 5'b00000; err_set = 1'b1; end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 1'b1;
        nxt_st    = (bus.OP == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        ior_d    = 1'b1;
        if (rdy) nxt_st = S_MEMWB;
        else if (tmo) begin
          err_set = 1'b1;
          nxt_st  = S_FETCH;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        nxt_st     = S_FETCH;
      end
      S_MEMWR: begin
        ior_d     = 1'b1;
        mem_write = 1'b1;
        if (rdy) nxt_st = S_FETCH;
        else if (tmo) begin
          err_set = 1'b1;
          nxt_st  = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nxt_st    = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        nxt_st    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a       = 1'b1;
        alu_op          = 2'b01;
        pc_source       = 2'b01;
        pc_write_cond   = (bus.OP == OP_BEQ);
        pc_write_cond_n = (bus.OP == OP_BNE);
        nxt_st          = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        // PC already holds PC+4 here, so JAL links straight from it.
        if (bus.OP == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
        nxt_st = S_FETCH;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (bus.OP == OP_ORI) begin
          alu_op = 2'b11;
          ext_op = 1'b0;
        end else begin
          alu_op = 2'b00;
          ext_op = 1'b1;
        end
        nxt_st = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        nxt_st    = S_FETCH;
      end
      default: nxt_st = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_st <= S_FETCH;
      led_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      cur_st <= nxt_st;
      led_q  <= led_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  // Write strobes are gated by rst so nothing writes while reset is held.
  assign bus.PCWrite      = pc_write & rst;
  assign bus.PCWriteCond  = pc_write_cond & rst;
  assign bus.PCWriteCondN = pc_write_cond_n & rst;
  assign bus.MemRead      = mem_read & rst;
  assign bus.MemWrite     = mem_write & rst;
  assign bus.IRWrite      = ir_write & rst;
  assign bus.RegWrite     = reg_write & rst;
  assign bus.IorD         = ior_d;
  assign bus.ALUSrcA      = alu_src_a;
  assign bus.ExtOp        = ext_op;
  assign bus.PCSource     = pc_source;
  assign bus.ALUOp        = alu_op;
  assign bus.ALUSrcB      = alu_src_b;
  assign bus.RegDst       = reg_dst;
  assign bus.MemtoReg     = mem_to_reg;
  assign bus.LED          = led_q;
  assign bus.state        = cur_st;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_multi_control_hs.sv
// Scoreboard bench for multi_control_hs: instructions expand into per-cycle expectations.
module tb_multi_control_hs;
  localparam int TMO = 4;
  localparam int CW  = 3;
`ifdef MULTI_CTRL_HS_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  typedef struct packed {
    logic pcw, pcwc, pcwcn, iord, mrd, mwr, irw, rw, asa, ext;
    logic [1:0] pcs, aluop, asb, rdst, m2r;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    ctl_t       c;
    logic       err;
    logic [4:0] led;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  obs_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic       m_err;
  logic [4:0] m_led;
  logic [5:0] ops [9] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J, OP_JAL};

  multi_control_hs_if bus();
  multi_control_hs #(.TIMEOUT(TMO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Output table per state, straight from the control description.
  function automatic ctl_t ctl_of(input int st, input logic [5:0] op, input logic rdy);
    ctl_t c;
    c = '0;
    case (st)
      0:  begin c.mrd = 1; c.asb = 2'b01; if (rdy) begin c.irw = 1; c.pcw = 1; end end
      1:  begin c.asb = 2'b11; c.ext = 1; end
      2:  begin c.asa = 1; c.asb = 2'b10; c.ext = 1; end
      3:  begin c.mrd = 1; c.iord = 1; end
      4:  begin c.rw = 1; c.m2r = 2'b01; end
      5:  begin c.iord = 1; c.mwr = 1; end
      6:  begin c.asa = 1; c.aluop = 2'b10; end
      7:  begin c.rw = 1; c.rdst = 2'b01; end
      8:  begin c.asa = 1; c.aluop = 2'b01; c.pcs = 2'b01;
                c.pcwc = (op == OP_BEQ); c.pcwcn = (op == OP_BNE); end
      9:  begin c.pcw = 1; c.pcs = 2'b10;
                if (op == OP_JAL) begin c.rw = 1; c.rdst = 2'b10; c.m2r = 2'b10; end end
      10: begin c.asa = 1; c.asb = 2'b10;
                if (op == OP_ORI) begin c.aluop = 2'b11; c.ext = 0; end
                else begin c.aluop = 2'b00; c.ext = 1; end end
      11: c.rw = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [4:0] cls(input logic [5:0] op);
    if (op == OP_J || op == OP_JAL) return 5'b10000;
    if (op == OP_BEQ || op == OP_BNE) return 5'b01000;
    if (op == OP_LW) return 5'b00100;
    if (op == OP_SW) return 5'b00010;
    if (op == OP_R || op == OP_ADDI || op == OP_ORI) return 5'b00001;
    return 5'b00000;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.st = bus.state;     a.err = bus.err;      a.led = bus.LED;
    a.c.pcw = bus.PCWrite; a.c.pcwc = bus.PCWriteCond; a.c.pcwcn = bus.PCWriteCondN;
    a.c.iord = bus.IorD;  a.c.mrd = bus.MemRead; a.c.mwr = bus.MemWrite;
    a.c.irw = bus.IRWrite; a.c.rw = bus.RegWrite; a.c.asa = bus.ALUSrcA;
    a.c.ext = bus.ExtOp;  a.c.pcs = bus.PCSource; a.c.aluop = bus.ALUOp;
    a.c.asb = bus.ALUSrcB; a.c.rdst = bus.RegDst; a.c.m2r = bus.MemtoReg;
    return a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    obs_t e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = sample();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle%0d outputs got st=%0d ctl=%h err=%b led=%b want st=%0d ctl=%h err=%b led=%b",
                 cyc, a.st, a.c, a.err, a.led, e.st, e.c, e.err, e.led);
      end
    end
  end

  task automatic drive(input int st, input logic [5:0] op, input logic rdy);
    obs_t e;
    bus.OP        = op;
    bus.mem_ready = HS ? rdy : 1'($urandom_range(0, 1));
    e.st  = 4'(st);
    e.c   = ctl_of(st, op, HS ? rdy : 1'b1);
    e.err = m_err;
    e.led = m_led;
    exp_q.push_back(e);
  endtask

  task automatic emit(input int st, input logic [5:0] op, input logic rdy);
    drive(st, op, rdy);
    @(posedge clk);
    #1;
  endtask

  // wf/wm: not-ready cycles before ready in FETCH / data-memory state; above TMO means abort.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input bit rst_in_wr);
    int path[$];
    if (op == OP_R) path = '{0, 1, 6, 7};
    else if (op == OP_LW) path = '{0, 1, 2, 3, 4};
    else if (op == OP_SW) path = '{0, 1, 2, 5};
    else if (op == OP_BEQ || op == OP_BNE) path = '{0, 1, 8};
    else if (op == OP_J || op == OP_JAL) path = '{0, 1, 9};
    else if (op == OP_ADDI || op == OP_ORI) path = '{0, 1, 10, 11};
    else path = '{0, 1};
    foreach (path[i]) begin
      int st, w;
      bit mem;
      st  = path[i];
      mem = (st == 0 || st == 3 || st == 5);
      w   = !HS ? 0 : (st == 0) ? wf : mem ? wm : 0;
      if (rst_in_wr && st == 5) begin
        drive(st, op, 1'b0);
        #6;
        rst = 1'b0;
        #1;
        chk("rst_memwrite_drop", 32'(bus.MemWrite), 0);
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_err_clear", 32'(bus.err), 0);
        chk("rst_regwrite", 32'(bus.RegWrite), 0);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        m_err = 1'b0;
        m_led = 5'b0;
        chk("rst_release_state", 32'(bus.state), 0);
        return;
      end
      if (w > TMO) begin
        repeat (TMO + 1) emit(st, op, 1'b0);
        m_err = 1'b1;
        return;
      end
      repeat (w) emit(st, op, 1'b0);
      emit(st, op, mem ? 1'b1 : 1'($urandom_range(0, 1)));
      if (st == 1) begin
        m_led = cls(op);
        if (cls(op) == 5'b0) m_err = 1'b1;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    bus.OP        = 6'b0;
    bus.mem_ready = 1'b0;
    m_err         = 1'b0;
    m_led         = 5'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(bus.state), 0);
    chk("reset_err", 32'(bus.err), 0);
    chk("reset_led", 32'(bus.LED), 0);
    chk("reset_memread", 32'(bus.MemRead), 0);
    chk("reset_pcwrite", 32'(bus.PCWrite), 0);
    chk("reset_irwrite", 32'(bus.IRWrite), 0);
    rst = 1'b1;

    run_instr(OP_R, 0, 0, 0);
    run_instr(OP_LW, 0, 3, 0);
    run_instr(OP_BNE, 0, 0, 0);
    run_instr(OP_BEQ, 0, 0, 0);
    run_instr(OP_JAL, 0, 0, 0);
    run_instr(OP_J, 1, 0, 0);
    run_instr(OP_ORI, 0, 0, 0);
    run_instr(OP_ADDI, 2, 0, 0);
    run_instr(OP_SW, 1, 2, 0);
    run_instr(OP_LW, TMO, TMO, 0);
    run_instr(OP_R, TMO + 1, 0, 0);
    run_instr(6'b111111, 0, 0, 0);
    run_instr(OP_SW, 0, TMO + 3, 0);
    run_instr(OP_LW, 0, TMO + 1, 0);

    for (int n = 0; n < 200; n++) begin
      int wf, wm;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 8)];
      wf = ($urandom_range(0, 9) == 0) ? TMO + 1 + $urandom_range(0, 2) : $urandom_range(0, 2);
      wm = ($urandom_range(0, 9) == 0) ? TMO + 1 + $urandom_range(0, 2) : $urandom_range(0, TMO);
      run_instr(op, wf, wm, 0);
    end

    run_instr(OP_SW, 0, 1, 1);
    run_instr(OP_R, 0, 0, 0);
    run_instr(OP_LW, 2, 1, 0);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
